fetch_npc: RTL and testbench

- Next-PC generation stage of the out-of-order core's front end.
- Owns the architectural fetch PC register, which drives both the instruction fetch request and the pc input of the gshare direction predictor.
- Holds a direct-mapped branch target buffer (BTB). Each cycle it combines the BTB hit/target with the predictor's predict_take to choose the next PC.
- The BTB is trained at ROB commit. Flush redirects take priority over everything else.

---
 rtl/rv32im_types.sv | 34 +++
 rtl/fetch_npc_btb_array.sv | 66 ++++++
 rtl/fetch_npc.sv | 100 ++++++++++
 tb/tb_fetch_npc.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32im_types.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rv32im_types                                              |
// | Brief    : Shared RV32IM opcode constants and front-end types.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package rv32im_types;

    localparam logic [6:0] op_b_lui   = 7'b0110111;
    localparam logic [6:0] op_b_auipc = 7'b0010111;
    localparam logic [6:0] op_b_jal   = 7'b1101111;
    localparam logic [6:0] op_b_jalr  = 7'b1100111;
    localparam logic [6:0] op_b_br    = 7'b1100011;
    localparam logic [6:0] op_b_load  = 7'b0000011;
    localparam logic [6:0] op_b_store = 7'b0100011;
    localparam logic [6:0] op_b_imm   = 7'b0010011;
    localparam logic [6:0] op_b_reg   = 7'b0110011;

    // Tag is sized for the smallest sensible BTB; unused upper bits are always written as zero.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        logic        uncond;
    } btb_entry_t;

    typedef enum logic [1:0] {
        S_RESET    = 2'd0,
        S_FETCH    = 2'd1,
        S_REDIRECT = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_npc_btb_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : btb_array                                                 |
// | Brief    : Direct-mapped BTB, async lookup, one synchronous write.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module btb_array
    import rv32im_types::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_lookup_pc,
    output logic        o_hit,
    output logic [31:0] o_target,
    output logic        o_uncond,
    input  logic        i_we,
    input  logic [31:0] i_wr_pc,
    input  logic [31:0] i_wr_target,
    input  logic        i_wr_uncond
);

    localparam int c_ENTRIES = 1 << IDX_BITS;
    localparam int c_TAG_LSB = IDX_BITS + 2;

    btb_entry_t r_mem [c_ENTRIES];

    logic [IDX_BITS-1:0] w_rd_idx;
    logic [IDX_BITS-1:0] w_wr_idx;
    logic [29:0]         w_rd_tag;
    btb_entry_t          w_rd_entry;
    btb_entry_t          w_wr_entry;
    logic                w_unused;

    assign w_rd_idx   = i_lookup_pc[IDX_BITS+1:2];
    assign w_wr_idx   = i_wr_pc[IDX_BITS+1:2];
    assign w_rd_tag   = 30'(i_lookup_pc >> c_TAG_LSB);
    assign w_rd_entry = r_mem[w_rd_idx];
    assign w_unused   = ^{i_lookup_pc[1:0], i_wr_pc[1:0]};

    assign o_hit    = w_rd_entry.valid && (w_rd_entry.tag == w_rd_tag);
    assign o_target = w_rd_entry.target;
    assign o_uncond = w_rd_entry.uncond;

    always_comb begin
        w_wr_entry        = '0;
        w_wr_entry.valid  = 1'b1;
        w_wr_entry.tag    = 30'(i_wr_pc >> c_TAG_LSB);
        w_wr_entry.target = i_wr_target;
        w_wr_entry.uncond = i_wr_uncond;
    end

    // Lookup is combinational from the current array, so a same-cycle write is seen next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_mem[i].valid <= 1'b0;
            end
        end else if (i_we) begin
            r_mem[w_wr_idx] <= w_wr_entry;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_npc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fetch_npc                                                 |
// | Brief    : Fetch PC register, BTB-based next-PC selection, redirect. |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module fetch_npc
    import rv32im_types::*;
#(
    parameter int          BTB_IDX_BITS = 6,
    parameter logic [31:0] RESET_PC     = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        rob_commit,
    input  logic [31:0] commit_pc,
    input  logic [6:0]  commit_opcode,
    input  logic [31:0] commit_target,
    input  logic        br_take,
    input  logic        predict_take,
    input  logic        fetch_ready,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic        fetch_pred_take,
    output logic [31:0] fetch_pred_target
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_fetch_valid;

    logic         w_btb_hit;
    logic [31:0]  w_btb_target;
    logic         w_btb_uncond;
    logic         w_pred_take;
    logic [31:0]  w_npc;
    logic         w_train_we;
    logic         w_train_uncond;

    assign w_train_uncond = (commit_opcode == op_b_jal);
    assign w_train_we     = rob_commit &&
                            (((commit_opcode == op_b_br) && br_take) || w_train_uncond);

    btb_array #(
        .IDX_BITS (BTB_IDX_BITS)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .i_lookup_pc (r_pc),
        .o_hit       (w_btb_hit),
        .o_target    (w_btb_target),
        .o_uncond    (w_btb_uncond),
        .i_we        (w_train_we),
        .i_wr_pc     (commit_pc),
        .i_wr_target (commit_target),
        .i_wr_uncond (w_train_uncond)
    );

    assign w_pred_take = w_btb_hit && (w_btb_uncond || predict_take);
    assign w_npc       = w_pred_take ? w_btb_target : (r_pc + 32'd4);

    assign pc                = r_pc;
    assign fetch_valid       = r_fetch_valid;
    // Prediction outputs read as zero whenever no request is being presented.
    assign fetch_pred_take   = r_fetch_valid && w_pred_take;
    assign fetch_pred_target = r_fetch_valid ? w_npc : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RESET;
            r_pc          <= RESET_PC;
            r_fetch_valid <= 1'b0;
        end else if (flush) begin
            r_state       <= S_REDIRECT;
            r_pc          <= flush_pc;
            r_fetch_valid <= 1'b0;
        end else begin
            case (r_state)
                S_RESET, S_REDIRECT: begin
                    r_state       <= S_FETCH;
                    r_fetch_valid <= 1'b1;
                end
                S_FETCH: begin
                    r_fetch_valid <= 1'b1;
                    if (r_fetch_valid && fetch_ready) begin
                        r_pc <= w_npc;
                    end
                end
                default: begin
                    r_state       <= S_RESET;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_npc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_fetch_npc                                              |
// | Brief    : Directed and randomized checks of fetch_npc vs a model.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_fetch_npc;

    localparam logic [31:0] c_RST_PC = 32'h1eceb000;
    localparam logic [6:0]  c_OP_BR  = 7'b1100011;
    localparam logic [6:0]  c_OP_JAL = 7'b1101111;
    localparam logic [6:0]  c_OP_JR  = 7'b1100111;
    localparam logic [6:0]  c_OP_ALU = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        rob_commit = 1'b0;
    logic [31:0] commit_pc = '0;
    logic [6:0]  commit_opcode = '0;
    logic [31:0] commit_target = '0;
    logic        br_take = 1'b0;
    logic        predict_take = 1'b0;
    logic        fetch_ready = 1'b0;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        fetch_pred_take;
    logic [31:0] fetch_pred_target;

    int checks = 0;
    int errors = 0;

    fetch_npc dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .flush_pc          (flush_pc),
        .rob_commit        (rob_commit),
        .commit_pc         (commit_pc),
        .commit_opcode     (commit_opcode),
        .commit_target     (commit_target),
        .br_take           (br_take),
        .predict_take      (predict_take),
        .fetch_ready       (fetch_ready),
        .pc                (pc),
        .fetch_valid       (fetch_valid),
        .fetch_pred_take   (fetch_pred_take),
        .fetch_pred_target (fetch_pred_target)
    );

    always #5 clk = ~clk;

    // Reference model: BTB as plain arrays, phase 0 = post-reset bubble, 1 = fetching, 2 = redirect bubble.
    bit          m_v   [64];
    logic [31:0] m_tag [64];
    logic [31:0] m_tgt [64];
    bit          m_u   [64];
    logic [31:0] m_pc = c_RST_PC;
    int          m_phase = 0;

    function automatic int bidx(input logic [31:0] a);
        return int'((a >> 2) & 32'd63);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_v[bidx(a)] && (m_tag[bidx(a)] == (a >> 8));
    endfunction

    function automatic bit m_take(input logic [31:0] a, input bit pt);
        return m_hit(a) && (m_u[bidx(a)] || pt);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] a, input bit pt);
        return m_take(a, pt) ? m_tgt[bidx(a)] : a + 32'd4;
    endfunction

    task automatic tick();
        bit          r, f, rdy, we, jal;
        logic [31:0] fpc, cpc, ctgt, npc;
        r    = rst;
        f    = flush;
        rdy  = fetch_ready;
        fpc  = flush_pc;
        cpc  = commit_pc;
        ctgt = commit_target;
        jal  = (commit_opcode == c_OP_JAL);
        we   = rob_commit && (((commit_opcode == c_OP_BR) && br_take) || jal);
        npc  = m_next(m_pc, predict_take);
        @(posedge clk);
        #1;
        if (r) begin
            m_pc    = c_RST_PC;
            m_phase = 0;
            foreach (m_v[i]) m_v[i] = 1'b0;
        end else begin
            if (we) begin
                m_v[bidx(cpc)]   = 1'b1;
                m_tag[bidx(cpc)] = cpc >> 8;
                m_tgt[bidx(cpc)] = ctgt;
                m_u[bidx(cpc)]   = jal;
            end
            if (f) begin
                m_pc    = fpc;
                m_phase = 2;
            end else if (m_phase != 1) begin
                m_phase = 1;
            end else if (rdy) begin
                m_pc = npc;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", fetch_valid); end
        checks++;
        if (pc !== c_RST_PC) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, c_RST_PC); end
        checks++;
        if (fetch_pred_take !== 1'b0 || fetch_pred_target !== 32'd0) begin
            errors++; $display("FAIL reset_pred: got take %b target %h expected 0/0", fetch_pred_take, fetch_pred_target);
        end
        tick();
    endtask

    task automatic test_sequential();
        fetch_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (pc !== c_RST_PC + 32'(4 * i) || fetch_valid !== 1'b1 || fetch_pred_take !== 1'b0) begin
                errors++;
                $display("FAIL seq_fetch[%0d]: got pc %h valid %b take %b expected pc %h valid 1 take 0",
                         i, pc, fetch_valid, fetch_pred_take, c_RST_PC + 32'(4 * i));
            end
            if (i < 2) tick();
        end
    endtask

    task automatic test_stall();
        fetch_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (pc !== 32'h1eceb008 || fetch_valid !== 1'b1 || fetch_pred_target !== 32'h1eceb00c) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got pc %h valid %b target %h expected 1eceb008 1 1eceb00c",
                         i, pc, fetch_valid, fetch_pred_target);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        rob_commit = 1'b1; commit_opcode = c_OP_BR; commit_pc = 32'h1eceb010;
        commit_target = 32'h1eceb100; br_take = 1'b1;
        tick();
        rob_commit = 1'b0;
        fetch_ready = 1'b1;
        tick();
        tick();
        predict_take = 1'b1;
        #1;
        checks++;
        if (pc !== 32'h1eceb010 || fetch_pred_take !== 1'b1 || fetch_pred_target !== 32'h1eceb100) begin
            errors++;
            $display("FAIL br_taken: got pc %h take %b target %h expected 1eceb010 1 1eceb100",
                     pc, fetch_pred_take, fetch_pred_target);
        end
        tick();
        checks++;
        if (pc !== 32'h1eceb100) begin errors++; $display("FAIL br_taken_pc: got %h expected 1eceb100", pc); end
        flush = 1'b1; flush_pc = 32'h1eceb010;
        tick();
        flush = 1'b0;
        tick();
        predict_take = 1'b0;
        #1;
        checks++;
        if (fetch_pred_take !== 1'b0 || fetch_pred_target !== 32'h1eceb014) begin
            errors++;
            $display("FAIL br_not_pred: got take %b target %h expected 0 1eceb014", fetch_pred_take, fetch_pred_target);
        end
        tick();
        checks++;
        if (pc !== 32'h1eceb014) begin errors++; $display("FAIL br_not_pred_pc: got %h expected 1eceb014", pc); end
    endtask

    task automatic test_jal();
        rob_commit = 1'b1; commit_opcode = c_OP_JAL; commit_pc = 32'h1eceb020;
        commit_target = 32'h1eceb400; br_take = 1'b0;
        tick();
        rob_commit = 1'b0;
        tick();
        tick();
        predict_take = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h1eceb020 || fetch_pred_take !== 1'b1 || fetch_pred_target !== 32'h1eceb400) begin
            errors++;
            $display("FAIL jal_pred: got pc %h take %b target %h expected 1eceb020 1 1eceb400",
                     pc, fetch_pred_take, fetch_pred_target);
        end
        tick();
        checks++;
        if (pc !== 32'h1eceb400) begin errors++; $display("FAIL jal_pc: got %h expected 1eceb400", pc); end
    endtask

    task automatic test_flush();
        flush = 1'b1; flush_pc = 32'h1eceb020;
        tick();
        flush = 1'b0;
        tick();
        flush = 1'b1; flush_pc = 32'h1eceb800; fetch_ready = 1'b1;
        #1;
        checks++;
        if (fetch_pred_take !== 1'b1) begin errors++; $display("FAIL flush_hit_setup: got take %b expected 1", fetch_pred_take); end
        tick();
        flush = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h1eceb800 || fetch_valid !== 1'b0) begin
            errors++; $display("FAIL flush_bubble: got pc %h valid %b expected 1eceb800 0", pc, fetch_valid);
        end
        tick();
        checks++;
        if (pc !== 32'h1eceb800 || fetch_valid !== 1'b1) begin
            errors++; $display("FAIL flush_resume: got pc %h valid %b expected 1eceb800 1", pc, fetch_valid);
        end
    endtask

    task automatic test_alias();
        flush = 1'b1; flush_pc = 32'h1eceb110;
        tick();
        flush = 1'b0;
        tick();
        predict_take = 1'b1;
        #1;
        checks++;
        if (fetch_pred_take !== 1'b0 || fetch_pred_target !== 32'h1eceb114) begin
            errors++;
            $display("FAIL alias_miss: got take %b target %h expected 0 1eceb114", fetch_pred_take, fetch_pred_target);
        end
    endtask

    task automatic test_reset_clears_btb();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fetch_ready = 1'b1;
        predict_take = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        #1;
        checks++;
        if (pc !== 32'h1eceb020 || fetch_pred_take !== 1'b0 || fetch_pred_target !== 32'h1eceb024) begin
            errors++;
            $display("FAIL reset_btb_clear: got pc %h take %b target %h expected 1eceb020 0 1eceb024",
                     pc, fetch_pred_take, fetch_pred_target);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [4];
        ops[0] = c_OP_BR; ops[1] = c_OP_JAL; ops[2] = c_OP_JR; ops[3] = c_OP_ALU;
        for (int n = 0; n < 800; n++) begin
            rst           = ($urandom_range(0, 149) == 0);
            flush         = (m_phase != 0) && ($urandom_range(0, 7) == 0);
            flush_pc      = c_RST_PC + 32'(4 * $urandom_range(0, 47)) + (($urandom_range(0, 3) == 0) ? 32'h100 : 32'h0);
            rob_commit    = $urandom_range(0, 1) == 1;
            commit_opcode = ops[$urandom_range(0, 3)];
            commit_pc     = c_RST_PC + 32'(4 * $urandom_range(0, 47)) + (($urandom_range(0, 3) == 0) ? 32'h100 : 32'h0);
            commit_target = c_RST_PC + 32'(4 * $urandom_range(0, 47));
            br_take       = $urandom_range(0, 1) == 1;
            predict_take  = $urandom_range(0, 1) == 1;
            fetch_ready   = $urandom_range(0, 3) != 0;
            #1;
            checks++;
            if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", n, pc, m_pc); end
            checks++;
            if (fetch_valid !== (m_phase == 1)) begin
                errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", n, fetch_valid, m_phase == 1);
            end
            checks++;
            if (fetch_pred_take !== ((m_phase == 1) && m_take(m_pc, predict_take))) begin
                errors++; $display("FAIL rnd_take[%0d]: got %b expected %b", n, fetch_pred_take,
                                   (m_phase == 1) && m_take(m_pc, predict_take));
            end
            checks++;
            if (fetch_pred_target !== ((m_phase == 1) ? m_next(m_pc, predict_take) : 32'd0)) begin
                errors++; $display("FAIL rnd_target[%0d]: got %h expected %h", n, fetch_pred_target,
                                   (m_phase == 1) ? m_next(m_pc, predict_take) : 32'd0);
            end
            tick();
        end
        rst = 1'b0; flush = 1'b0; rob_commit = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jal();
        test_flush();
        test_alias();
        test_reset_clears_btb();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
